// File: rtl/mem_port_arbiter.sv
// Shares one downstream memory port between the I-side fetch and D-side load/store requesters.
// Default: fixed D priority with I anti-starvation counter; define ARB_RR_EN for round-robin arbitration.
module mem_port_arbiter #(
    parameter int WAIT_LIMIT    = 4,
    parameter int WAIT_CNT_BITS = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_i_read,
    input  logic [31:0] mem_i_address,
    output logic        mem_i_resp,
    output logic [31:0] mem_i_rdata,
    input  logic        mem_d_read,
    input  logic        mem_d_write,
    input  logic [31:0] mem_d_address,
    input  logic [31:0] mem_d_wdata,
    input  logic [3:0]  mem_d_byte_enable,
    output logic        mem_d_resp,
    output logic [31:0] mem_d_rdata,
    output logic        pmem_read,
    output logic        pmem_write,
    output logic [31:0] pmem_address,
    output logic [31:0] pmem_wdata,
    output logic [3:0]  pmem_byte_enable,
    input  logic        pmem_resp,
    input  logic [31:0] pmem_rdata,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_pmemRead;
    logic        r_pmemWrite;
    logic [31:0] r_pmemAddress;
    logic [31:0] r_pmemWdata;
    logic [3:0]  r_pmemByteEnable;

    logic w_dReq;
    logic w_grantI;
    logic w_grantD;
    logic w_respI;
    logic w_respD;

    assign w_dReq = mem_d_read | mem_d_write;

`ifdef ARB_RR_EN
    logic r_lastGrantD;

    // On a tie the side that did not win last time goes next
    always_comb begin
        w_grantI = 1'b0;
        w_grantD = 1'b0;
        if (w_dReq && mem_i_read) begin
            w_grantD = ~r_lastGrantD;
            w_grantI = r_lastGrantD;
        end else begin
            w_grantD = w_dReq;
            w_grantI = mem_i_read;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lastGrantD <= 1'b0;
        end else if (r_state == IDLE) begin
            if (w_grantI) begin
                r_lastGrantD <= 1'b0;
            end else if (w_grantD) begin
                r_lastGrantD <= 1'b1;
            end
        end
    end
`else
    logic [WAIT_CNT_BITS-1:0] r_waitCnt;
    logic                     w_starved;

    assign w_starved = (r_waitCnt >= WAIT_CNT_BITS'(WAIT_LIMIT));
    assign w_grantI  = mem_i_read & (~w_dReq | w_starved);
    assign w_grantD  = w_dReq & ~w_grantI;

    // Counts how many times a pending I request has lost to D in a row
    always_ff @(posedge clk) begin
        if (rst) begin
            r_waitCnt <= '0;
        end else if (r_state == IDLE) begin
            if (!mem_i_read || w_grantI) begin
                r_waitCnt <= '0;
            end else if (w_grantD) begin
                r_waitCnt <= r_waitCnt + 1'b1;
            end
        end
    end
`endif

    // Grant latch: downstream attributes are frozen for the whole service state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= IDLE;
            r_pmemRead       <= 1'b0;
            r_pmemWrite      <= 1'b0;
            r_pmemAddress    <= '0;
            r_pmemWdata      <= '0;
            r_pmemByteEnable <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grantI) begin
                        r_state          <= SERVE_I;
                        r_pmemRead       <= 1'b1;
                        r_pmemWrite      <= 1'b0;
                        r_pmemAddress    <= mem_i_address;
                        r_pmemWdata      <= '0;
                        r_pmemByteEnable <= 4'hF;
                    end else if (w_grantD) begin
                        r_state          <= SERVE_D;
                        r_pmemRead       <= mem_d_read & ~mem_d_write;
                        r_pmemWrite      <= mem_d_write;
                        r_pmemAddress    <= mem_d_address;
                        r_pmemWdata      <= mem_d_wdata;
                        r_pmemByteEnable <= mem_d_byte_enable;
                    end
                end
                SERVE_I, SERVE_D: begin
                    if (pmem_resp) begin
                        r_state     <= IDLE;
                        r_pmemRead  <= 1'b0;
                        r_pmemWrite <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_pmemRead  <= 1'b0;
                    r_pmemWrite <= 1'b0;
                end
            endcase
        end
    end

    // A completion coinciding with reset is abandoned, not forwarded
    assign w_respI = (r_state == SERVE_I) & pmem_resp & ~rst;
    assign w_respD = (r_state == SERVE_D) & pmem_resp & ~rst;

    assign mem_i_resp  = w_respI;
    assign mem_d_resp  = w_respD;
    assign mem_i_rdata = w_respI ? pmem_rdata : 32'h0;
    assign mem_d_rdata = w_respD ? pmem_rdata : 32'h0;

    assign pmem_read        = r_pmemRead;
    assign pmem_write       = r_pmemWrite;
    assign pmem_address     = r_pmemAddress;
    assign pmem_wdata       = r_pmemWdata;
    assign pmem_byte_enable = r_pmemByteEnable;
    assign busy             = (r_state == SERVE_I) || (r_state == SERVE_D);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: expected downstream transactions are queued as requests
// are driven and popped when the arbiter issues them. Honors ARB_RR_EN for the contention order.
module tb_mem_port_arbiter;

    localparam int WAIT_LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_i_read;
    logic [31:0] mem_i_address;
    logic        mem_i_resp;
    logic [31:0] mem_i_rdata;
    logic        mem_d_read;
    logic        mem_d_write;
    logic [31:0] mem_d_address;
    logic [31:0] mem_d_wdata;
    logic [3:0]  mem_d_byte_enable;
    logic        mem_d_resp;
    logic [31:0] mem_d_rdata;
    logic        pmem_read;
    logic        pmem_write;
    logic [31:0] pmem_address;
    logic [31:0] pmem_wdata;
    logic [3:0]  pmem_byte_enable;
    logic        pmem_resp;
    logic [31:0] pmem_rdata;
    logic        busy;

    typedef struct {
        bit          isD;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } txn_t;

    txn_t expQ[$];
    int   testsRun    = 0;
    int   testsFailed = 0;

    mem_port_arbiter #(.WAIT_LIMIT(WAIT_LIMIT), .WAIT_CNT_BITS(3)) dut (
        .clk               (clk),
        .rst               (rst),
        .mem_i_read        (mem_i_read),
        .mem_i_address     (mem_i_address),
        .mem_i_resp        (mem_i_resp),
        .mem_i_rdata       (mem_i_rdata),
        .mem_d_read        (mem_d_read),
        .mem_d_write       (mem_d_write),
        .mem_d_address     (mem_d_address),
        .mem_d_wdata       (mem_d_wdata),
        .mem_d_byte_enable (mem_d_byte_enable),
        .mem_d_resp        (mem_d_resp),
        .mem_d_rdata       (mem_d_rdata),
        .pmem_read         (pmem_read),
        .pmem_write        (pmem_write),
        .pmem_address      (pmem_address),
        .pmem_wdata        (pmem_wdata),
        .pmem_byte_enable  (pmem_byte_enable),
        .pmem_resp         (pmem_resp),
        .pmem_rdata        (pmem_rdata),
        .busy              (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic iRead, input logic [31:0] iAddr, input logic dRead,
                                 input logic dWrite, input logic [31:0] dAddr,
                                 input logic [31:0] dWdata, input logic [3:0] dBe);
        mem_i_read        = iRead;
        mem_i_address     = iAddr;
        mem_d_read        = dRead;
        mem_d_write       = dWrite;
        mem_d_address     = dAddr;
        mem_d_wdata       = dWdata;
        mem_d_byte_enable = dBe;
    endtask

    task automatic pushI(input logic [31:0] addr);
        txn_t t;
        t.isD = 1'b0; t.rd = 1'b1; t.wr = 1'b0; t.addr = addr; t.wdata = 32'h0; t.be = 4'hF;
        expQ.push_back(t);
    endtask

    task automatic pushD(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be);
        txn_t t;
        t.isD = 1'b1; t.rd = rd & ~wr; t.wr = wr; t.addr = addr; t.wdata = wdata; t.be = be;
        expQ.push_back(t);
    endtask

    // Acts as the downstream memory for one transaction and checks everything the arbiter shows
    task automatic serviceOne(input int latency, input logic [31:0] rdata, input bit dropAfter,
                              input bit moveIAddr, output int waited);
        txn_t e;
        bit   seen;
        seen   = 1'b0;
        waited = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #2;
            waited++;
            if (pmem_read || pmem_write) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            checkOutput("grant_timeout", 32'd0, 32'd1);
            return;
        end
        if (expQ.size() == 0) begin
            checkOutput("sb_underflow", 32'd1, 32'd0);
            return;
        end
        e = expQ.pop_front();
        checkOutput("pmem_read", pmem_read, e.rd);
        checkOutput("pmem_write", pmem_write, e.wr);
        checkOutput("pmem_address", pmem_address, e.addr);
        checkOutput("pmem_wdata", pmem_wdata, e.wdata);
        checkOutput("pmem_be", pmem_byte_enable, e.be);
        checkOutput("busy_serve", busy, 1'b1);
        if (moveIAddr) mem_i_address = 32'h0000_0080;
        for (int k = 1; k < latency; k++) begin
            @(posedge clk); #2;
            checkOutput("hold_addr", pmem_address, e.addr);
            checkOutput("hold_rw", {pmem_read, pmem_write}, {e.rd, e.wr});
            checkOutput("early_resp", {mem_i_resp, mem_d_resp}, 2'b00);
        end
        pmem_resp  = 1'b1;
        pmem_rdata = rdata;
        #1;
        checkOutput("i_resp", mem_i_resp, !e.isD);
        checkOutput("d_resp", mem_d_resp, e.isD);
        checkOutput("i_rdata", mem_i_rdata, e.isD ? 32'h0 : rdata);
        checkOutput("d_rdata", mem_d_rdata, e.isD ? rdata : 32'h0);
        @(posedge clk); #1;
        pmem_resp  = 1'b0;
        pmem_rdata = 32'h0;
        if (dropAfter) begin
            if (e.isD) begin
                mem_d_read  = 1'b0;
                mem_d_write = 1'b0;
            end else begin
                mem_i_read = 1'b0;
            end
        end
        #1;
        checkOutput("idle_busy", busy, 1'b0);
        checkOutput("idle_rw", {pmem_read, pmem_write}, 2'b00);
        checkOutput("resp_pulse", {mem_i_resp, mem_d_resp}, 2'b00);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int  waited;
        bit  isD;
        rst        = 1'b1;
        pmem_resp  = 1'b0;
        pmem_rdata = 32'h0;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_rw", {pmem_read, pmem_write}, 2'b00);
        checkOutput("rst_addr", pmem_address, 32'h0);
        checkOutput("rst_wdata", pmem_wdata, 32'h0);
        checkOutput("rst_be", pmem_byte_enable, 4'h0);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_resp", {mem_i_resp, mem_d_resp}, 2'b00);
        rst = 1'b0;

        // I-only read with three-cycle downstream latency
        applyStimulus(1'b1, 32'h0000_0060, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        pushI(32'h0000_0060);
        serviceOne(3, 32'h0010_0093, 1'b1, 1'b0, waited);
        checkOutput("i_grant_latency", waited, 32'd1);

        // D write with partial byte mask
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 4'b0011);
        pushD(1'b0, 1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 4'b0011);
        serviceOne(4, 32'h0, 1'b1, 1'b0, waited);

        // Read and write together resolve as a write
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_2000, 32'h1234_5678, 4'hF);
        pushD(1'b1, 1'b1, 32'h0000_2000, 32'h1234_5678, 4'hF);
        serviceOne(1, 32'h0, 1'b1, 1'b0, waited);

        // D read returns data
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_3000, 32'h0, 4'hF);
        pushD(1'b1, 1'b0, 32'h0000_3000, 32'h0, 4'hF);
        serviceOne(2, 32'hCAFE_F00D, 1'b1, 1'b0, waited);

        // I address moves mid-service; latched value must hold
        applyStimulus(1'b1, 32'h0000_0040, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        pushI(32'h0000_0040);
        serviceOne(3, 32'h0000_0013, 1'b1, 1'b1, waited);

        // Continuous contention from a fresh reset
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        applyStimulus(1'b1, 32'h0000_0100, 1'b1, 1'b0, 32'h0000_0200, 32'h55AA_55AA, 4'hC);
        for (int i = 0; i < 10; i++) begin
`ifdef ARB_RR_EN
            isD = ((i % 2) == 0);
`else
            isD = ((i % (WAIT_LIMIT + 1)) != WAIT_LIMIT);
`endif
            if (isD) pushD(1'b1, 1'b0, 32'h0000_0200, 32'h55AA_55AA, 4'hC);
            else     pushI(32'h0000_0100);
        end
        for (int i = 0; i < 10; i++) begin
            serviceOne(2, 32'h0000_1000 + i, 1'b0, 1'b0, waited);
        end
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        checkOutput("sb_leftover", expQ.size(), 32'd0);

        // Reset lands mid D write; a stray completion afterwards is ignored
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_4000, 32'h0000_0011, 4'hF);
        @(posedge clk); #1;
        checkOutput("mid_pre_write", pmem_write, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        #1;
        checkOutput("mid_rst_write", pmem_write, 1'b0);
        checkOutput("mid_rst_busy", busy, 1'b0);
        checkOutput("mid_rst_resp", mem_d_resp, 1'b0);
        pmem_resp  = 1'b1;
        pmem_rdata = 32'h0000_0BAD;
        #1;
        checkOutput("stray_resp", {mem_i_resp, mem_d_resp}, 2'b00);
        checkOutput("stray_rdata", mem_d_rdata | mem_i_rdata, 32'h0);
        @(posedge clk); #1;
        pmem_resp  = 1'b0;
        pmem_rdata = 32'h0;
        #1;
        checkOutput("stray_busy", busy, 1'b0);
        checkOutput("stray_rw", {pmem_read, pmem_write}, 2'b00);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
